sysid_info_regs: RTL

- Parametrised Avalon-MM system-identification slave; successor to the two-word ID/timestamp block.
- Exposes build-time constants: ID, timestamp, version, clock frequency.
- Adds a writable scratch register and a free-running uptime counter with coherent 64-bit snapshot reads.
- Sits on the system interconnect's control slave, polled by software at boot and for liveness checks.

---
 rtl/sysid_info_regs_if.sv | 31 +++
 rtl/sysid_info_regs.sv | 101 ++++++++++
 2 files changed

// File: rtl/sysid_info_regs_if.sv
// Avalon-MM control-slave bundle for the system-identification register block.
// The master drives the transfer; the slave returns registered read data.
interface sysid_info_regs_if;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address,
    output read,
    output write,
    output writedata,
    output byteenable,
    input  readdata,
    input  readdatavalid
  );

  modport slave (
    input  address,
    input  read,
    input  write,
    input  writedata,
    input  byteenable,
    output readdata,
    output readdatavalid
  );
endinterface

// File: rtl/sysid_info_regs.sv
// System-identification slave: build constants, scratch register and a free-running
// uptime counter whose 64-bit value is read coherently as LO then HI.
module sysid_info_regs #(
  parameter logic [31:0] ID_VALUE     = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
  parameter logic [31:0] VERSION      = 32'h0001_0000,
  parameter logic [31:0] CLK_FREQ_HZ  = 32'd50_000_000,
  parameter logic [31:0] SCRATCH_INIT = 32'h0000_0000,
  parameter int unsigned CNT_W        = 48
) (
  input  logic              clock,
  input  logic              reset_n,
  sysid_info_regs_if.slave  bus
);

  localparam logic [2:0] AddrId      = 3'd0;
  localparam logic [2:0] AddrTstamp  = 3'd1;
  localparam logic [2:0] AddrVersion = 3'd2;
  localparam logic [2:0] AddrFreq    = 3'd3;
  localparam logic [2:0] AddrScratch = 3'd4;
  localparam logic [2:0] AddrUpLo    = 3'd5;
  localparam logic [2:0] AddrUpHi    = 3'd6;
  localparam logic [2:0] AddrCtrl    = 3'd7;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      scratch_q, scratch_d;
  logic [31:0]      hi_snap_q, hi_snap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             rvalid_q;

  logic [63:0]      cnt_ext;
  logic             wr_en;
  logic             cnt_clr;
  logic [31:0]      rd_word;

  // A read in the same cycle as a write wins; the write is dropped entirely.
  assign wr_en   = bus.write & ~bus.read;
  assign cnt_clr = wr_en & (bus.address == AddrCtrl) & bus.writedata[0];
  assign cnt_ext = 64'(cnt_q);

  always_comb begin
    cnt_d = cnt_clr ? '0 : cnt_q + CNT_W'(1);
  end

  always_comb begin
    scratch_d = scratch_q;
    if (wr_en && (bus.address == AddrScratch)) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.byteenable[b]) begin
          scratch_d[8*b +: 8] = bus.writedata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_word = 32'h0;
    unique case (bus.address)
      AddrId:      rd_word = ID_VALUE;
      AddrTstamp:  rd_word = TIMESTAMP;
      AddrVersion: rd_word = VERSION;
      AddrFreq:    rd_word = CLK_FREQ_HZ;
      AddrScratch: rd_word = scratch_q;
      AddrUpLo:    rd_word = cnt_ext[31:0];
      AddrUpHi:    rd_word = hi_snap_q;
      AddrCtrl:    rd_word = 32'h0;
    endcase
  end

  // HI is latched from the same counter sample that LO returns, so no tear on carry.
  always_comb begin
    hi_snap_d  = hi_snap_q;
    readdata_d = readdata_q;
    if (bus.read) begin
      readdata_d = rd_word;
      if (bus.address == AddrUpLo) begin
        hi_snap_d = cnt_ext[63:32];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      scratch_q  <= SCRATCH_INIT;
      hi_snap_q  <= 32'h0;
      readdata_q <= 32'h0;
      rvalid_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      scratch_q  <= scratch_d;
      hi_snap_q  <= hi_snap_d;
      readdata_q <= readdata_d;
      rvalid_q   <= bus.read;
    end
  end

  assign bus.readdata      = readdata_q;
  assign bus.readdatavalid = rvalid_q;

endmodule
